// File: rtl/commit_monitor_if.sv
// Commit-stream and trace-sink signal bundle for commit_monitor.
// Signal suffixes are seen from the monitor side: slave = monitor, master = CPU/sink side.
`default_nettype none

interface commit_monitor_if #(
  parameter int PC_WIDTH = 32
) ();
  logic                commit_i;
  logic [PC_WIDTH-1:0] commit_pc_i;
  logic [PC_WIDTH-1:0] commit_pre_pc_i;
  logic                trace_valid_o;
  logic                trace_ready_i;
  logic [PC_WIDTH-1:0] trace_pc_o;
  logic [PC_WIDTH-1:0] trace_npc_o;
  logic                trace_err_o;

  modport slave (
    input  commit_i, commit_pc_i, commit_pre_pc_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_npc_o, trace_err_o
  );

  modport master (
    output commit_i, commit_pc_i, commit_pre_pc_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_npc_o, trace_err_o
  );
endinterface

`default_nettype wire

// File: rtl/commit_monitor.sv
// ============================================================================
// commit_monitor : control-flow continuity checker, counters, hang detector
//                  and show-ahead trace FIFO for the CPU commit stream.
// Optional macro : COMMIT_MON_FIRST_ERR_EN (capture first continuity error)
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_monitor #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  FIFO_DEPTH = 8,
  parameter int                  TIMEOUT    = 1024,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  commit_monitor_if.slave     bus,
  output logic [31:0]         commit_cnt_o,
  output logic [15:0]         err_cnt_o,
  output logic [15:0]         ovf_cnt_o,
  output logic [1:0]          state_o,
  output logic                hang_o,
  output logic [PC_WIDTH-1:0] first_err_pc_o,
  output logic [PC_WIDTH-1:0] first_err_exp_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 2 * PC_WIDTH + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_HANG = 2'd2
  } state_t;

  state_t              state_q;
  logic                hang_q;
  logic [IW-1:0]       idle_q;
  logic [PC_WIDTH-1:0] exp_q;
  logic [31:0]         commit_cnt_q;
  logic [15:0]         err_cnt_q;
  logic [15:0]         ovf_cnt_q;

  logic [RW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_q, wr_d;
  logic [AW:0]         rd_q, rd_d;
  logic                valid_q, valid_d;
  logic [RW-1:0]       head_q, head_d;

  logic                err;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [RW-1:0]       rec;

  assign err  = bus.commit_i && (bus.commit_pc_i != exp_q);
  assign rec  = {err, bus.commit_pre_pc_i, bus.commit_pc_i};
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop  = valid_q && bus.trace_ready_i;
  assign push = bus.commit_i && (!full || pop);
  assign drop = bus.commit_i && full && !pop;

  assign rd_d    = rd_q + {{AW{1'b0}}, pop};
  assign wr_d    = wr_q + {{AW{1'b0}}, push};
  assign valid_d = (wr_d != rd_d);
  // The incoming record becomes the head when it lands on the next read slot.
  assign head_d  = (push && (rd_d == wr_q)) ? rec : mem_q[rd_d[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      if (valid_d) begin
        head_q <= head_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q        <= RESET_PC;
      commit_cnt_q <= '0;
      err_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
    end else if (bus.commit_i) begin
      exp_q        <= bus.commit_pre_pc_i;
      commit_cnt_q <= commit_cnt_q + 32'd1;
      if (err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (drop && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  // Idle counter freezes in HANG; any commit returns to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT;
      hang_q  <= 1'b0;
      idle_q  <= '0;
    end else if (bus.commit_i) begin
      state_q <= S_RUN;
      hang_q  <= 1'b0;
      idle_q  <= '0;
    end else if (state_q != S_HANG) begin
      idle_q <= idle_q + IW'(1);
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_q <= S_HANG;
        hang_q  <= 1'b1;
      end
    end
  end

`ifdef COMMIT_MON_FIRST_ERR_EN
  logic                fe_vld_q;
  logic [PC_WIDTH-1:0] fe_pc_q;
  logic [PC_WIDTH-1:0] fe_exp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_vld_q <= 1'b0;
      fe_pc_q  <= '0;
      fe_exp_q <= '0;
    end else if (err && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_pc_q  <= bus.commit_pc_i;
      fe_exp_q <= exp_q;
    end
  end

  assign first_err_pc_o  = fe_pc_q;
  assign first_err_exp_o = fe_exp_q;
`else
  assign first_err_pc_o  = '0;
  assign first_err_exp_o = '0;
`endif

  assign bus.trace_valid_o = valid_q;
  assign bus.trace_pc_o    = head_q[PC_WIDTH-1:0];
  assign bus.trace_npc_o   = head_q[2*PC_WIDTH-1:PC_WIDTH];
  assign bus.trace_err_o   = head_q[RW-1];

  assign commit_cnt_o = commit_cnt_q;
  assign err_cnt_o    = err_cnt_q;
  assign ovf_cnt_o    = ovf_cnt_q;
  assign state_o      = state_q;
  assign hang_o       = hang_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
`default_nettype none

module tb_commit_monitor;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] commit_cnt;
  logic [15:0] err_cnt, ovf_cnt;
  logic [1:0]  state;
  logic        hang;
  logic [31:0] fe_pc, fe_exp;

  int errors = 0;
  int checks = 0;

  commit_monitor_if #(.PC_WIDTH(32)) bus ();

  commit_monitor #(
    .PC_WIDTH(32), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .commit_cnt_o(commit_cnt), .err_cnt_o(err_cnt), .ovf_cnt_o(ovf_cnt),
    .state_o(state), .hang_o(hang),
    .first_err_pc_o(fe_pc), .first_err_exp_o(fe_exp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct { logic err; logic [31:0] pc; logic [31:0] npc; } rec_t;
  rec_t        q[$];
  logic [31:0] m_exp, m_cnt, m_fe_pc, m_fe_exp;
  int          m_err, m_ovf, m_idle;
  bit          m_seen, m_fe_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_exp = 32'h0; m_cnt = 0; m_err = 0; m_ovf = 0; m_idle = 0;
    m_seen = 0; m_fe_seen = 0; m_fe_pc = 0; m_fe_exp = 0;
  endtask

  task automatic model_step(input bit c, input logic [31:0] pc, input logic [31:0] npc, input bit rdy);
    bit pop, full, e;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    e    = c && (pc != m_exp);
    if (pop) q.delete(0);
    if (c) begin
      m_cnt = m_cnt + 1;
      if (e && m_err < 65535) m_err++;
      if (e && !m_fe_seen) begin
        m_fe_seen = 1; m_fe_pc = pc; m_fe_exp = m_exp;
      end
      if (full && !pop) begin
        if (m_ovf < 65535) m_ovf++;
      end else begin
        q.push_back('{err: e, pc: pc, npc: npc});
      end
      m_exp  = npc;
      m_seen = 1;
      m_idle = 0;
    end else if (m_idle < 100000) begin
      m_idle++;
    end
  endtask

  task automatic check_all();
    int exp_state;
    exp_state = (m_idle >= TMO) ? 2 : (m_seen ? 1 : 0);
    chk("trace_valid", bus.trace_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("trace_pc",  bus.trace_pc_o,  q[0].pc);
      chk("trace_npc", bus.trace_npc_o, q[0].npc);
      chk("trace_err", bus.trace_err_o, q[0].err);
    end
    chk("commit_cnt", commit_cnt, m_cnt);
    chk("err_cnt",    err_cnt,    m_err);
    chk("ovf_cnt",    ovf_cnt,    m_ovf);
    chk("state",      state,      exp_state);
    chk("hang",       hang,       exp_state == 2);
`ifdef COMMIT_MON_FIRST_ERR_EN
    chk("first_err_pc",  fe_pc,  m_fe_pc);
    chk("first_err_exp", fe_exp, m_fe_exp);
`else
    chk("first_err_pc",  fe_pc,  0);
    chk("first_err_exp", fe_exp, 0);
`endif
  endtask

  // Drive one cycle at a falling edge, advance the model, check at the next falling edge.
  task automatic cyc(input bit c, input logic [31:0] pc, input logic [31:0] npc, input bit rdy);
    bus.commit_i = c; bus.commit_pc_i = pc; bus.commit_pre_pc_i = npc; bus.trace_ready_i = rdy;
    model_step(c, pc, npc, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.commit_i = 0; bus.commit_pc_i = 0; bus.commit_pre_pc_i = 0; bus.trace_ready_i = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    check_all();
  endtask

  initial begin
    int burst;
    logic [31:0] pc, npc;
    bit c, rdy;

    // Basic continuous stream
    do_reset();
    chk("rst_valid", bus.trace_valid_o, 0);
    chk("rst_pc", bus.trace_pc_o, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_state", state, 0);
    cyc(1, 32'h0, 32'h4, 1);
    chk("t1_valid", bus.trace_valid_o, 1);
    chk("t1_pc0", bus.trace_pc_o, 32'h0);
    cyc(1, 32'h4, 32'h8, 1);
    chk("t1_pc1", bus.trace_pc_o, 32'h4);
    cyc(1, 32'h8, 32'hC, 1);
    chk("t1_pc2", bus.trace_pc_o, 32'h8);
    cyc(0, 32'h0, 32'h0, 1);
    chk("t1_cnt", commit_cnt, 3);
    chk("t1_err", err_cnt, 0);
    chk("t1_state", state, 1);

    // Continuity error
    do_reset();
    cyc(1, 32'h0, 32'h4, 1);
    cyc(1, 32'h10, 32'h14, 0);
    cyc(1, 32'h14, 32'h18, 1);
    chk("t2_head_pc", bus.trace_pc_o, 32'h10);
    chk("t2_head_err", bus.trace_err_o, 1);
    chk("t2_err_cnt", err_cnt, 1);
`ifdef COMMIT_MON_FIRST_ERR_EN
    chk("t2_fe_pc", fe_pc, 32'h10);
    chk("t2_fe_exp", fe_exp, 32'h4);
`endif
    cyc(0, 32'h0, 32'h0, 1);
    chk("t2_next_err", bus.trace_err_o, 0);
    chk("t2_next_pc", bus.trace_pc_o, 32'h14);

    // Overflow with ready low, then drain
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 32'(4 * i), 32'(4 * i + 4), 0);
    chk("t3_ovf", ovf_cnt, 2);
    chk("t3_valid", bus.trace_valid_o, 1);
    chk("t3_head", bus.trace_pc_o, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 32'h0, 32'h0, 1);
      if (i < 7) chk("t3_drain_pc", bus.trace_pc_o, 32'(4 * (i + 1)));
    end
    chk("t3_empty", bus.trace_valid_o, 0);

    // Full FIFO, push and pop together
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'(4 * i), 32'(4 * i + 4), 0);
    cyc(1, 32'h20, 32'h24, 1);
    chk("t4_no_ovf", ovf_cnt, 0);
    cyc(1, 32'h24, 32'h28, 0);
    chk("t4_still_full", ovf_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 32'h0, 32'h0, 1);
      if (i == 6) chk("t4_last_pc", bus.trace_pc_o, 32'h20);
    end

    // Hang detection and recovery
    do_reset();
    cyc(1, 32'h0, 32'h4, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 32'h0, 32'h0, 1);
      if (i == 14) chk("t5_no_hang_yet", hang, 0);
    end
    chk("t5_hang", hang, 1);
    chk("t5_state_hang", state, 2);
    cyc(1, 32'h4, 32'h8, 1);
    chk("t5_state_run", state, 1);
    chk("t5_rec_err", bus.trace_err_o, 0);
    chk("t5_err_cnt", err_cnt, 0);

    // Asynchronous reset with records queued
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 32'(4 * i), 32'(4 * i + 4), 0);
    #2;
    rst = 1;
    #1;
    chk("t6_valid", bus.trace_valid_o, 0);
    chk("t6_cnt", commit_cnt, 0);
    chk("t6_state", state, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    check_all();
    cyc(1, 32'h0, 32'h4, 1);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_rec_err", bus.trace_err_o, 0);

    // Random traffic
    do_reset();
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if (burst > 0) begin
        c = 0; burst--;
      end else begin
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(10, 24);
        c = ($urandom_range(0, 99) < 60);
      end
      pc  = m_exp;
      if ($urandom_range(0, 9) == 0) pc = m_exp + 32'(4 * $urandom_range(1, 4));
      npc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pc + 32'h4;
      rdy = ($urandom_range(0, 99) < 45);
      cyc(c, pc, npc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
